// File: rtl/hack_boot_pkg.sv
// rtl/hack_boot_pkg.sv - shared states and constants for the Hack boot loader
package hack_boot_pkg;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        RUN,
        ERROR
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_CSUM    = 2'b11;

endpackage

// File: rtl/boot_timeout_timer.sv
// rtl/boot_timeout_timer.sv - inter-byte idle timer, expires after TIMEOUT_CYC enabled cycles
module boot_timeout_timer #(
    parameter int TIMEOUT_CYC = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at LAST so an idle state never wraps back to a fresh window.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hack_boot_loader.sv
// rtl/hack_boot_loader.sv - UART-fed program loader that holds the Hack CPU in reset until its RAM is filled
// Optional trailing XOR checksum byte enabled by HACK_BOOT_CHECKSUM_EN.
module hack_boot_loader
    import hack_boot_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int DEPTH       = 32768,
    parameter int TIMEOUT_CYC = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              boot_done,
    output logic [1:0]        boot_err
);

`ifdef HACK_BOOT_CHECKSUM_EN
    localparam boot_state_e AFTER_DATA = CHECK;
`else
    localparam boot_state_e AFTER_DATA = RUN;
`endif

    boot_state_e       state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       idx_q, idx_d;
    logic [7:0]        hi_q, hi_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]       rom_wdata_q, rom_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              boot_done_q, boot_done_d;
    logic [1:0]        err_q, err_d;
`ifdef HACK_BOOT_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic tmo_enable;
    logic tmo_expired;

    assign tmo_enable = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA_HI) ||
                        (state_q == DATA_LO) || (state_q == CHECK);

    boot_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (reset),
        .clear  (rx_valid),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        err_d       = err_q;
`ifdef HACK_BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        // One cycle behind the state so the last RAM write always lands before release.
        cpu_reset_d = (state_q != RUN);
        boot_done_d = (state_q == RUN);

        if (rx_valid) begin
            case (state_q)
                WAIT_SYNC, ERROR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = LEN_HI;
                        err_d   = ERR_NONE;
`ifdef HACK_BOOT_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                LEN_HI: begin
                    len_hi_d = rx_data;
                    state_d  = LEN_LO;
                end
                LEN_LO: begin
                    len_d = {len_hi_q, rx_data};
                    idx_d = '0;
                    if (32'({len_hi_q, rx_data}) > DEPTH) begin
                        state_d = ERROR;
                        err_d   = ERR_LEN;
                    end else if ({len_hi_q, rx_data} == 16'd0) begin
                        state_d = AFTER_DATA;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
                DATA_HI: begin
                    hi_d    = rx_data;
                    state_d = DATA_LO;
`ifdef HACK_BOOT_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                end
                DATA_LO: begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = idx_q[ADDR_W-1:0];
                    rom_wdata_d = {hi_q, rx_data};
                    idx_d       = idx_q + 16'd1;
                    state_d     = (idx_q == len_q - 16'd1) ? AFTER_DATA : DATA_HI;
`ifdef HACK_BOOT_CHECKSUM_EN
                    csum_d      = csum_q ^ rx_data;
`endif
                end
`ifdef HACK_BOOT_CHECKSUM_EN
                CHECK: begin
                    if (rx_data == csum_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = ERROR;
                        err_d   = ERR_CSUM;
                    end
                end
`endif
                default: ;
            endcase
        end else if (tmo_expired) begin
            state_d = ERROR;
            err_d   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_SYNC;
            len_hi_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            hi_q        <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            boot_done_q <= 1'b0;
            err_q       <= ERR_NONE;
`ifdef HACK_BOOT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            hi_q        <= hi_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            boot_done_q <= boot_done_d;
            err_q       <= err_d;
`ifdef HACK_BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign boot_done = boot_done_q;
    assign boot_err  = err_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// tb/tb_hack_boot_loader.sv - scoreboard bench for hack_boot_loader (checksum cases under HACK_BOOT_CHECKSUM_EN)
module tb_hack_boot_loader;

    localparam int ADDR_W = 15;
    localparam int DEPTH  = 32768;
    localparam int TMO    = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic              boot_done;
    logic [1:0]        boot_err;

    hack_boot_loader #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rom_we   (rom_we),
        .rom_addr (rom_addr),
        .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset),
        .boot_done(boot_done),
        .boot_err (boot_err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          we_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [15:0] words[8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rom_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                chk("we_unexpected", {1'b0, rom_addr, rom_wdata}, 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("we_word", {1'b0, rom_addr, rom_wdata}, mon_exp);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n);
        logic [7:0]  cs;
        logic [15:0] len;
        cs  = 8'h00;
        len = 16'(n);
        send_byte(8'hA5);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, 15'(i), words[i]});
            cs = cs ^ words[i][15:8] ^ words[i][7:0];
            send_byte(words[i][15:8]);
            send_byte(words[i][7:0]);
        end
`ifdef HACK_BOOT_CHECKSUM_EN
        send_byte(cs);
`endif
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_cpu_reset_entry"}, 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        chk({tag, "_boot_done"}, 32'(boot_done), 32'd1);
        chk({tag, "_boot_err"}, 32'(boot_err), 32'd0);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int w0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_we", 32'(rom_we), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_wdata", 32'(rom_wdata), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        chk("rst_boot_err", 32'(boot_err), 32'd0);
        reset = 1'b0;

        words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
        send_frame(3);
        check_run("three");
        chk("three_we_cnt", 32'(we_cnt), 32'd3);
        send_byte(8'hA5);
        send_byte(8'h00);
        chk("run_ignores_rx", 32'(boot_done), 32'd1);

        do_reset();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
        chk("junk_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("junk_boot_err", 32'(boot_err), 32'd0);
        words[0] = 16'hABCD;
        send_frame(1);
        check_run("one");

        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h11);
        n = 0;
        while (boot_err == 2'b00 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd100);
        chk("tmo_err", 32'(boot_err), 32'd1);
        chk("tmo_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("tmo_boot_done", 32'(boot_done), 32'd0);
        words[0] = 16'hCAFE; words[1] = 16'hBEEF;
        send_frame(2);
        check_run("after_tmo");

        do_reset();
        w0 = we_cnt;
        send_byte(8'hA5); send_byte(8'h80); send_byte(8'h01);
        chk("len_err", 32'(boot_err), 32'd2);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        chk("len_err_sticky", 32'(boot_err), 32'd2);
        chk("len_no_we", 32'(we_cnt - w0), 32'd0);
        chk("len_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(8'hA5);
        chk("len_err_cleared", 32'(boot_err), 32'd0);

        do_reset();
        w0 = we_cnt;
        send_frame(0);
        check_run("zero");
        chk("zero_no_we", 32'(we_cnt - w0), 32'd0);

`ifdef HACK_BOOT_CHECKSUM_EN
        do_reset();
        exp_q.push_back({1'b0, 15'd0, 16'h1234});
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        chk("csum_err", 32'(boot_err), 32'd3);
        chk("csum_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk("csum_boot_done", 32'(boot_done), 32'd0);
        chk("csum_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
        exp_q.push_back({1'b0, 15'd0, 16'h1111});
        exp_q.push_back({1'b0, 15'd1, 16'h2222});
        send_byte(8'h11); send_byte(8'h11); send_byte(8'h22); send_byte(8'h22);
        @(negedge clk);
        chk("mid_pre_addr", 32'(rom_addr), 32'd1);
        chk("mid_sb_empty", 32'(exp_q.size()), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_addr", 32'(rom_addr), 32'd0);
        chk("mid_rst_wdata", 32'(rom_wdata), 32'd0);
        chk("mid_rst_we", 32'(rom_we), 32'd0);
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_rst_boot_done", 32'(boot_done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        words[0] = 16'h0A0B; words[1] = 16'h1C1D; words[2] = 16'h2E2F; words[3] = 16'h3031;
        send_frame(4);
        check_run("four");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
